// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: forwarding, load-use/branch/memory-wait control, event counters
module hazard_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    rs1d,
    input  logic [4:0]    rs2d,
    input  logic [4:0]    rs1e,
    input  logic [4:0]    rs2e,
    input  logic [4:0]    rde,
    input  logic [4:0]    rdm,
    input  logic [4:0]    rdw,
    input  logic          resultsrce0,
    input  logic          pcsrce,
    input  logic          regwritem,
    input  logic          regwritew,
    input  logic          memreqm,
    input  logic          memreadym,
    output logic          stallf,
    output logic          stalld,
    output logic          stalle,
    output logic          stallm,
    output logic          flushd,
    output logic          flushe,
    output logic          flushw,
    output logic [1:0]    forwardae,
    output logic [1:0]    forwardbe,
    output logic          memerr,
    output logic [CW-1:0] cnt_lwstall,
    output logic [CW-1:0] cnt_flush,
    output logic [CW-1:0] cnt_memwait
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WW-1:0]   r_waitcnt;
    logic [WW-1:0]   w_waitcnt_nxt;
    logic [CW-1:0]   r_cnt_lw;
    logic [CW-1:0]   r_cnt_fl;
    logic [CW-1:0]   r_cnt_mw;

    logic w_err;
    logic w_memstall;
    logic w_lwraw;
    logic w_lw_evt;
    logic w_fl_evt;

    assign w_err      = (r_state == ST_ERR);
    assign w_memstall = ~w_err & memreqm & ~memreadym;
    assign w_lwraw    = resultsrce0 & (rde != 5'd0) & ((rs1d == rde) | (rs2d == rde));
    assign w_fl_evt   = ~w_err & ~w_memstall & pcsrce;
    assign w_lw_evt   = ~w_err & ~w_memstall & ~pcsrce & w_lwraw;

    // M-stage result wins over W-stage: it is the younger write to the same register
    always_comb begin
        forwardae = 2'b00;
        if ((rs1e != 5'd0) && (rs1e == rdm) && regwritem)
            forwardae = 2'b10;
        else if ((rs1e != 5'd0) && (rs1e == rdw) && regwritew)
            forwardae = 2'b01;
    end

    always_comb begin
        forwardbe = 2'b00;
        if ((rs2e != 5'd0) && (rs2e == rdm) && regwritem)
            forwardbe = 2'b10;
        else if ((rs2e != 5'd0) && (rs2e == rdw) && regwritew)
            forwardbe = 2'b01;
    end

    // A memory stall freezes E too, so a taken branch there is simply replayed next cycle
    always_comb begin
        stallf = 1'b0;
        stalld = 1'b0;
        stalle = 1'b0;
        stallm = 1'b0;
        flushd = 1'b0;
        flushe = 1'b0;
        flushw = 1'b0;
        if (w_err || w_memstall) begin
            stallf = 1'b1;
            stalld = 1'b1;
            stalle = 1'b1;
            stallm = 1'b1;
            flushw = 1'b1;
        end else if (pcsrce) begin
            flushd = 1'b1;
            flushe = 1'b1;
        end else if (w_lwraw) begin
            stallf = 1'b1;
            stalld = 1'b1;
            flushe = 1'b1;
        end
    end

    // Leaving WAIT on any non-stalled cycle (ready, or request withdrawn) keeps waitcnt meaningful
    always_comb begin
        w_state_nxt   = r_state;
        w_waitcnt_nxt = r_waitcnt;
        case (r_state)
            ST_RUN: begin
                if (w_memstall) begin
                    w_state_nxt   = (MAX_WAIT == 1) ? ST_ERR : ST_WAIT;
                    w_waitcnt_nxt = WW'(1);
                end
            end
            ST_WAIT: begin
                if (!w_memstall) begin
                    w_state_nxt   = ST_RUN;
                    w_waitcnt_nxt = '0;
                end else if (r_waitcnt == WAIT_LAST) begin
                    w_state_nxt   = ST_ERR;
                end else begin
                    w_waitcnt_nxt = r_waitcnt + WW'(1);
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt   = ST_RUN;
                w_waitcnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_waitcnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_waitcnt <= w_waitcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_lw <= '0;
            r_cnt_fl <= '0;
            r_cnt_mw <= '0;
        end else begin
            if (w_lw_evt && (r_cnt_lw != CNT_MAX))
                r_cnt_lw <= r_cnt_lw + CW'(1);
            if (w_fl_evt && (r_cnt_fl != CNT_MAX))
                r_cnt_fl <= r_cnt_fl + CW'(1);
            if (w_memstall && (r_cnt_mw != CNT_MAX))
                r_cnt_mw <= r_cnt_mw + CW'(1);
        end
    end

    assign memerr      = w_err;
    assign cnt_lwstall = r_cnt_lw;
    assign cnt_flush   = r_cnt_fl;
    assign cnt_memwait = r_cnt_mw;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed and randomized self-checking bench for hazard_unit
module tb_hazard_unit;

    localparam int MW   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic          resultsrce0, pcsrce, regwritem, regwritew, memreqm, memreadym;
    logic          stallf, stalld, stalle, stallm, flushd, flushe, flushw;
    logic [1:0]    forwardae, forwardbe;
    logic          memerr;
    logic [CW-1:0] cnt_lwstall, cnt_flush, cnt_memwait;

    int checks   = 0;
    int failures = 0;

    bit m_err;
    int m_wait;
    int m_lw, m_fl, m_mw;

    hazard_unit #(.MAX_WAIT(MW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
        .rde(rde), .rdm(rdm), .rdw(rdw),
        .resultsrce0(resultsrce0), .pcsrce(pcsrce),
        .regwritem(regwritem), .regwritew(regwritew),
        .memreqm(memreqm), .memreadym(memreadym),
        .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
        .flushd(flushd), .flushe(flushe), .flushw(flushw),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .memerr(memerr),
        .cnt_lwstall(cnt_lwstall), .cnt_flush(cnt_flush), .cnt_memwait(cnt_memwait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rs != 0 && rs == rdm && regwritem) return 2'b10;
        if (rs != 0 && rs == rdw && regwritew) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_err = 0; m_wait = 0; m_lw = 0; m_fl = 0; m_mw = 0;
    endtask

    task automatic idle_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        resultsrce0 = 0; pcsrce = 0; regwritem = 0; regwritew = 0;
        memreqm = 0; memreadym = 0;
    endtask

    // Called at a falling edge with inputs already set; checks, then advances one clock
    task automatic step(input string tag);
        bit ms, lw;
        logic [6:0] exp_ctl;
        #1;
        if (!reset) model_reset();
        ms = !m_err && memreqm && !memreadym;
        lw = resultsrce0 && rde != 0 && (rs1d == rde || rs2d == rde);
        if (m_err || ms)  exp_ctl = 7'b1111_001;
        else if (pcsrce)  exp_ctl = 7'b0000_110;
        else if (lw)      exp_ctl = 7'b1100_010;
        else              exp_ctl = 7'b0000_000;
        chk({tag, ".ctl"}, {stallf, stalld, stalle, stallm, flushd, flushe, flushw}, exp_ctl);
        chk({tag, ".fwa"}, forwardae, fwd(rs1e));
        chk({tag, ".fwb"}, forwardbe, fwd(rs2e));
        chk({tag, ".memerr"}, memerr, m_err);
        chk({tag, ".cnt_lw"}, cnt_lwstall, m_lw);
        chk({tag, ".cnt_fl"}, cnt_flush, m_fl);
        chk({tag, ".cnt_mw"}, cnt_memwait, m_mw);
        if (reset) begin
            if (!m_err && !ms && pcsrce) m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
            if (!m_err && !ms && !pcsrce && lw) m_lw = (m_lw < CMAX) ? m_lw + 1 : CMAX;
            if (ms) begin
                m_mw = (m_mw < CMAX) ? m_mw + 1 : CMAX;
                m_wait++;
                if (m_wait >= MW) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0;
        step("rst");
        reset = 1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 0;
        @(negedge clk);
        chk("reset_memerr", memerr, 0);
        chk("reset_cnt", {cnt_lwstall, cnt_flush, cnt_memwait}, 0);
        step("reset");
        reset = 1;

        // load-use
        resultsrce0 = 1; rde = 5; rs1d = 5;
        step("lw_hit");
        rde = 0; rs1d = 0;
        step("lw_zero");
        chk("lw_cnt_one", cnt_lwstall, 1);
        resultsrce0 = 0;

        // forwarding priority
        rs1e = 3; rdm = 3; rdw = 3; regwritem = 1; regwritew = 1;
        rs2e = 3;
        step("fw_m");
        chk("fwa_m", forwardae, 2'b10);
        regwritem = 0;
        step("fw_w");
        chk("fwa_w", forwardae, 2'b01);
        rs1e = 0;
        step("fw_zero");
        chk("fwa_zero", forwardae, 2'b00);
        idle_inputs();

        // branch beats load-use
        do_reset();
        resultsrce0 = 1; rde = 7; rs2d = 7; pcsrce = 1;
        step("br_lw");
        idle_inputs();
        step("br_after");
        chk("br_cnt_fl", cnt_flush, 1);
        chk("br_cnt_lw", cnt_lwstall, 0);

        // three wait states then branch resolves
        do_reset();
        memreqm = 1; memreadym = 0; pcsrce = 1;
        repeat (3) step("mwait");
        memreadym = 1;
        step("mready");
        chk("mready_flushe", flushe, 1);
        idle_inputs();
        step("mdone");
        chk("memwait_eq3", cnt_memwait, 3);

        // timeout into absorbing error
        do_reset();
        memreqm = 1; memreadym = 0;
        repeat (MW) step("tmo");
        chk("tmo_memerr", memerr, 1);
        memreadym = 1;
        repeat (3) step("err_hold");
        chk("err_stallf", stallf, 1);
        reset = 0;
        #2;
        chk("err_async_clear", {memerr, cnt_memwait}, 0);
        @(negedge clk);
        step("err_rst");
        reset = 1;
        idle_inputs();
        step("err_post");
        chk("post_err_nostall", stallf, 0);

        // saturation
        do_reset();
        resultsrce0 = 1; rde = 9; rs2d = 9;
        repeat (20) step("sat");
        chk("sat_lw", cnt_lwstall, CMAX);
        idle_inputs();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 64 == 63) begin
                do_reset();
            end else begin
                rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
                rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
                rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
                rdw  = 5'($urandom_range(0, 3));
                resultsrce0 = 1'($urandom_range(0, 1));
                pcsrce      = ($urandom_range(0, 3) == 0);
                regwritem   = 1'($urandom_range(0, 1));
                regwritew   = 1'($urandom_range(0, 1));
                memreqm     = ($urandom_range(0, 1) == 0);
                memreadym   = ($urandom_range(0, 3) != 0);
                step("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
